// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint monitor: after an armed start marker, the observed bus must step
// through a programmed list of values and then show a done marker.
//
// state      | meaning
// IDLE       | no check since reset; results are all zero
// WAIT_START | armed, watching for the start marker
// RUN        | matching entries in order, timing the sequence
// DONE       | result latched and held until the next arm
module checkpoint_seq_monitor #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [AW:0]       cfg_len,
   input  logic [DATA_W-1:0] cfg_start_val,
   input  logic [DATA_W-1:0] cfg_done_val,
   input  logic [CNT_W-1:0]  cfg_timeout,
   input  logic              cfg_strict,
   input  logic              arm,
   input  logic [DATA_W-1:0] obs,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic              timeout_o,
   output logic [AW:0]       match_idx,
   output logic [CNT_W-1:0]  latency,
   output logic [DATA_W-1:0] fail_val
);

   typedef enum logic [1:0] {IDLE, WAIT_START, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] obs_q, obs_d;
   logic [DATA_W-1:0] obs_prev_q, obs_prev_d;
   logic [DATA_W-1:0] last_val_q, last_val_d;
   logic [DATA_W-1:0] fail_val_q, fail_val_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              to_q, to_d;
   logic [AW:0]       idx_q, idx_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;

   logic [DATA_W-1:0] exp_mem [DEPTH];
   logic [DATA_W-1:0] exp_cur;
   logic              hit_exp;
   logic              unexpected;

   assign busy = (state_q == WAIT_START) || (state_q == RUN);

   // Entry RAM keeps its contents across reset so a check can be replayed.
   always_ff @(posedge wb_clk_i) begin
      if (cfg_we && !busy) begin
         exp_mem[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      obs_d      = obs;
      obs_prev_d = obs_q;
      last_val_d = last_val_q;
      fail_val_d = fail_val_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      to_d       = to_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      tcnt_d     = tcnt_q;

      exp_cur    = exp_mem[idx_q[AW-1:0]];
      hit_exp    = (idx_q < cfg_len) && (obs_q == exp_cur);
      // A held value or a return to the last accepted value is not an error.
      unexpected = (obs_q != obs_prev_q) && !hit_exp && (obs_q != last_val_q);

      if (arm) begin
         state_d    = WAIT_START;
         pass_d     = 1'b0;
         fail_d     = 1'b0;
         to_d       = 1'b0;
         idx_d      = '0;
         lat_d      = '0;
         fail_val_d = '0;
         tcnt_d     = '0;
      end else begin
         case (state_q)
            WAIT_START: begin
               if (obs_q == cfg_start_val) begin
                  state_d    = RUN;
                  lat_d      = '0;
                  idx_d      = '0;
                  tcnt_d     = '0;
                  last_val_d = cfg_start_val;
               end
            end
            RUN: begin
               lat_d = (&lat_q) ? lat_q : lat_q + CNT_W'(1);
               if (hit_exp) begin
                  idx_d      = idx_q + (AW+1)'(1);
                  tcnt_d     = '0;
                  last_val_d = obs_q;
               end else if ((idx_q == cfg_len) && (obs_q == cfg_done_val)) begin
                  pass_d  = 1'b1;
                  state_d = DONE;
               end else if (cfg_strict && unexpected) begin
                  fail_d     = 1'b1;
                  fail_val_d = obs_q;
                  state_d    = DONE;
               end else if ((cfg_timeout != '0) && (tcnt_q == cfg_timeout - CNT_W'(1))) begin
                  fail_d     = 1'b1;
                  to_d       = 1'b1;
                  fail_val_d = obs_q;
                  state_d    = DONE;
               end else begin
                  tcnt_d = tcnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         obs_q      <= '0;
         obs_prev_q <= '0;
         last_val_q <= '0;
         fail_val_q <= '0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         to_q       <= 1'b0;
         idx_q      <= '0;
         lat_q      <= '0;
         tcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         obs_q      <= obs_d;
         obs_prev_q <= obs_prev_d;
         last_val_q <= last_val_d;
         fail_val_q <= fail_val_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         to_q       <= to_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         tcnt_q     <= tcnt_d;
      end
   end

   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout_o = to_q;
   assign match_idx = idx_q;
   assign latency   = lat_q;
   assign fail_val  = fail_val_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: a sequence-level model checked every cycle,
// plus literal expectations at the end of each directed scenario.
module tb_checkpoint_seq_monitor;

   localparam int DW = 16;
   localparam int DP = 64;
   localparam int CW = 32;
   localparam int AW = 6;

   localparam logic [DW-1:0] E0 = 16'h003E, E1 = 16'h0044, E2 = 16'h004A, E3 = 16'h0050;
   localparam logic [DW-1:0] ST = 16'hAB40, DN = 16'hAB51;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic [AW:0]   cfg_len = '0;
   logic [DW-1:0] cfg_start_val = '0;
   logic [DW-1:0] cfg_done_val = '0;
   logic [CW-1:0] cfg_timeout = '0;
   logic          cfg_strict = 1'b0;
   logic          arm = 1'b0;
   logic [DW-1:0] obs = '0;
   logic          busy, pass, fail, timeout_o;
   logic [AW:0]   match_idx;
   logic [CW-1:0] latency;
   logic [DW-1:0] fail_val;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   checkpoint_seq_monitor #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_len(cfg_len), .cfg_start_val(cfg_start_val), .cfg_done_val(cfg_done_val),
      .cfg_timeout(cfg_timeout), .cfg_strict(cfg_strict),
      .arm(arm), .obs(obs),
      .busy(busy), .pass(pass), .fail(fail), .timeout_o(timeout_o),
      .match_idx(match_idx), .latency(latency), .fail_val(fail_val)
   );

   // Sequence-level model: bus seen one and two cycles late, list position,
   // quiet time since last progress, and the result flags.
   logic [DW-1:0] m_mem [DP];
   logic [DW-1:0] m_bus1, m_bus2, m_accept, m_fval;
   bit            m_wait, m_run, m_pass, m_fail, m_to;
   int            m_idx;
   longint        m_quiet;
   logic [CW-1:0] m_lat;

   always @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         m_wait = 0; m_run = 0; m_pass = 0; m_fail = 0; m_to = 0;
         m_idx = 0; m_quiet = 0; m_lat = '0; m_fval = '0;
         m_bus1 = '0; m_bus2 = '0;
      end else begin
         if (cfg_we && !(m_wait || m_run)) m_mem[cfg_addr] = cfg_data;
         if (arm) begin
            m_wait = 1; m_run = 0; m_pass = 0; m_fail = 0; m_to = 0;
            m_idx = 0; m_quiet = 0; m_lat = '0; m_fval = '0;
         end else if (m_wait) begin
            if (m_bus1 == cfg_start_val) begin
               m_wait = 0; m_run = 1; m_idx = 0; m_quiet = 0; m_lat = '0;
            end
         end else if (m_run) begin
            if (m_lat != 32'hFFFF_FFFF) m_lat = m_lat + 1;
            m_accept = (m_idx == 0) ? cfg_start_val : m_mem[m_idx-1];
            if (m_idx < cfg_len && m_bus1 == m_mem[m_idx]) begin
               m_idx++; m_quiet = 0;
            end else if (m_idx == cfg_len && m_bus1 == cfg_done_val) begin
               m_pass = 1; m_run = 0;
            end else if (cfg_strict && m_bus1 != m_bus2 && m_bus1 != m_accept) begin
               m_fail = 1; m_fval = m_bus1; m_run = 0;
            end else if (cfg_timeout != 0 && m_quiet + 1 == cfg_timeout) begin
               m_fail = 1; m_to = 1; m_fval = m_bus1; m_run = 0;
            end else begin
               m_quiet++;
            end
         end
         m_bus2 = m_bus1;
         m_bus1 = obs;
      end
   end

   always @(negedge wb_clk_i) begin
      if (chk_en) begin
         n_cmp++;
         if (busy !== (m_wait || m_run) || pass !== m_pass || fail !== m_fail ||
             timeout_o !== m_to || match_idx !== AW'(m_idx) + 7'd0 || latency !== m_lat ||
             fail_val !== m_fval) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t dut busy=%0b pass=%0b fail=%0b to=%0b idx=%0d lat=%0d fval=%h | model busy=%0b pass=%0b fail=%0b to=%0b idx=%0d lat=%0d fval=%h",
                     $time, busy, pass, fail, timeout_o, match_idx, latency, fail_val,
                     m_wait || m_run, m_pass, m_fail, m_to, m_idx, m_lat, m_fval);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   task automatic hold(input logic [DW-1:0] v, input int n);
      obs = v;
      tick(n);
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   task automatic load(input int a, input logic [DW-1:0] d);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic set_cfg(input int len, input logic [DW-1:0] st, input logic [DW-1:0] dn,
                          input int to, input bit strict);
      cfg_len = (AW+1)'(len); cfg_start_val = st; cfg_done_val = dn;
      cfg_timeout = CW'(to); cfg_strict = strict;
   endtask

   // Start marker, four entries 100 cycles apart, then the done marker.
   task automatic run_body(input bit inject);
      hold(ST, 100);
      hold(E0, 100);
      if (inject) begin
         hold(E1, 40);
         hold(16'h1234, 60);
      end else begin
         hold(E1, 100);
      end
      hold(E2, 100);
      hold(E3, 100);
      hold(DN, 5);
   endtask

   task automatic run_std(input bit inject);
      arm_pulse();
      hold(16'h0000, 9);
      run_body(inject);
   endtask

   task automatic check_pass(input string tag, input int lat);
      check({tag, "_pass"}, 64'(pass), 64'd1);
      check({tag, "_fail"}, 64'(fail), 64'd0);
      check({tag, "_idx"}, 64'(match_idx), 64'd4);
      check({tag, "_lat"}, 64'(latency), 64'(lat));
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pass", 64'(pass), 64'd0);
      check("rst_fail", 64'(fail), 64'd0);
      check("rst_lat", 64'(latency), 64'd0);
      wb_rst_i = 1'b0;
      tick(1);

      load(0, E0); load(1, E1); load(2, E2); load(3, E3);

      // nominal strict pass
      set_cfg(4, ST, DN, 0, 1'b1);
      run_std(1'b0);
      check_pass("s1", 500);

      // stray value in strict mode
      run_std(1'b1);
      check("s2_fail", 64'(fail), 64'd1);
      check("s2_to", 64'(timeout_o), 64'd0);
      check("s2_fval", 64'(fail_val), 64'h1234);
      check("s2_idx", 64'(match_idx), 64'd2);
      check("s2_pass", 64'(pass), 64'd0);
      check("s2_lat", 64'(latency), 64'd240);

      // same stray value ignored when not strict
      set_cfg(4, ST, DN, 0, 1'b0);
      run_std(1'b1);
      check_pass("s2b", 500);

      // timeout 50 cycles after the second match
      set_cfg(4, ST, DN, 50, 1'b1);
      arm_pulse();
      hold(16'h0000, 9);
      hold(ST, 30);
      hold(E0, 30);
      hold(E1, 51);
      check("s3_early_fail", 64'(fail), 64'd0);
      check("s3_early_busy", 64'(busy), 64'd1);
      tick(1);
      check("s3_fail", 64'(fail), 64'd1);
      check("s3_to", 64'(timeout_o), 64'd1);
      check("s3_idx", 64'(match_idx), 64'd2);
      check("s3_fval", 64'(fail_val), 64'(E1));
      check("s3_lat", 64'(latency), 64'd110);

      // empty list: only the done marker is awaited
      set_cfg(0, 16'h00A5, 16'hFF5A, 0, 1'b1);
      arm_pulse();
      hold(16'h0000, 9);
      hold(16'h00A5, 37);
      hold(16'hFF5A, 5);
      check("s4_pass", 64'(pass), 64'd1);
      check("s4_lat", 64'(latency), 64'd37);
      check("s4_idx", 64'(match_idx), 64'd0);

      // reset mid-run, then replay with retained entries
      set_cfg(4, ST, DN, 0, 1'b1);
      arm_pulse();
      hold(16'h0000, 9);
      hold(ST, 100);
      hold(E0, 100);
      hold(E1, 20);
      wb_rst_i = 1'b1;
      tick(1);
      wb_rst_i = 1'b0;
      check("s5_busy", 64'(busy), 64'd0);
      check("s5_pass", 64'(pass), 64'd0);
      check("s5_fail", 64'(fail), 64'd0);
      check("s5_to", 64'(timeout_o), 64'd0);
      check("s5_idx", 64'(match_idx), 64'd0);
      check("s5_lat", 64'(latency), 64'd0);
      check("s5_fval", 64'(fail_val), 64'd0);
      tick(3);
      check("s5_idle_busy", 64'(busy), 64'd0);
      run_std(1'b0);
      check_pass("s5r", 500);

      // re-arm mid-run with an ignored entry write while busy
      arm_pulse();
      hold(16'h0000, 9);
      hold(ST, 100);
      hold(E0, 100);
      obs = E1;
      tick(20);
      load(0, 16'hDEAD);
      tick(29);
      check("s6_mid_idx", 64'(match_idx), 64'd2);
      arm_pulse();
      check("s6_rearm_busy", 64'(busy), 64'd1);
      check("s6_rearm_idx", 64'(match_idx), 64'd0);
      check("s6_rearm_lat", 64'(latency), 64'd0);
      hold(16'h0000, 8);
      run_body(1'b0);
      check_pass("s6", 500);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
- Hardware checkpoint monitor that observes a DATA_W-bit status bus (e.g. the checkbits driven on mprj_io[31:16]).
- After an armed start marker, the bus must present a programmed sequence of values in order, then a done marker.
- Reports pass/fail, measured cycle latency, progress index and the offending value.
- Sits in the user project beside the firmware-visible GPIO path, so MM/FIR/QS self-check and latency profiling run on-chip instead of only in the testbench.

Parameters:
- DATA_W, 16, width of observed bus and of expected entries.
- DEPTH, 64, number of expected-value entries; power of two.
- CNT_W, 32, width of the latency and timeout counters.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cfg_we  in  1  write expected entry; honoured only when busy=0.
- cfg_addr  in  $clog2(DEPTH)  entry index for cfg_we.
- cfg_data  in  DATA_W  entry value.
- cfg_len  in  $clog2(DEPTH)+1  number of entries to check, 0..DEPTH.
- cfg_start_val  in  DATA_W  start marker.
- cfg_done_val  in  DATA_W  done marker.
- cfg_timeout  in  CNT_W  maximum cycles between progress events; 0 disables.
- cfg_strict  in  1  1 = any unexpected bus change fails.
- arm  in  1  one-cycle pulse; starts a check.
- obs  in  DATA_W  observed bus, asynchronous to firmware.
- busy  out  1  high in WAIT_START and RUN.
- pass  out  1  sticky until next arm or reset.
- fail  out  1  sticky until next arm or reset.
- timeout_o  out  1  fail cause was timeout.
- match_idx  out  $clog2(DEPTH)+1  entries matched so far.
- latency  out  CNT_W  cycles from start detect to done detect; saturating.
- fail_val  out  DATA_W  obs_q value at the failure cycle.

Behaviour:
- obs is registered once into obs_q every cycle. All comparisons use obs_q, so start and done detection share the same 1-cycle offset and latency is exact.
- Reset: busy, pass, fail, timeout_o = 0; match_idx, latency, fail_val = 0; FSM = IDLE. Expected-entry RAM is not reset.
- Reset mid-operation aborts to IDLE with all outputs cleared.
- FSM states: IDLE, WAIT_START, RUN, DONE.
- IDLE:
  - arm -> WAIT_START; clear pass, fail, timeout_o, match_idx, latency, fail_val, and the timeout counter.
- WAIT_START:
  - obs_q == cfg_start_val -> RUN; latency = 0, idx = 0, timeout counter = 0.
  - No timeout applies while waiting for start.
- RUN: per cycle, in priority order:
  - (a) idx < cfg_len and obs_q == exp[idx]: idx++, match_idx++, timeout counter = 0.
  - (b) idx == cfg_len and obs_q == cfg_done_val: pass = 1 -> DONE.
  - (c) cfg_strict, obs_q != obs_q_prev, and obs_q is neither exp[idx] nor the last matched value (or cfg_start_val when idx = 0): fail = 1, fail_val = obs_q -> DONE.
  - (d) cfg_timeout != 0 and timeout counter == cfg_timeout-1 with no progress this cycle: fail = 1, timeout_o = 1, fail_val = obs_q -> DONE.
  - Otherwise the timeout counter increments.
  - latency increments every RUN cycle, including the cycle of (b), and saturates at all-ones.
- At most one entry matches per cycle. Equal consecutive entries therefore need the bus to hold the value for at least 2 cycles, or to change between them.
- cfg_len = 0: RUN waits only for cfg_done_val.
- Done marker seen before idx == cfg_len: not a pass. It is treated as an unexpected value (strict mode fails; non-strict mode ignores it).
- DONE:
  - Outputs hold; busy = 0.
  - arm -> WAIT_START with outputs cleared.
- arm while busy: restart immediately into WAIT_START; in-flight results are discarded.
- cfg_we while busy: ignored. cfg_* values other than the entries may change only while busy=0; their effect is otherwise undefined.

Test Plan:
- Load entries 0x003E, 0x0044, 0x004A, 0x0050; len=4; start=0xAB40; done=0xAB51; strict=1; timeout=0. Arm; drive 0xAB40 at cycle 10, entries at 110/210/310/410, 0xAB51 at 510 -> pass=1, fail=0, match_idx=4, latency=500.
- Same setup; drive 0x1234 at cycle 250 -> fail=1, timeout_o=0, fail_val=0x1234, match_idx=2, pass=0. Repeat with strict=0 -> 0x1234 is ignored and the run passes with latency=500.
- timeout=50; stop driving after the second entry at 210 -> fail=1 and timeout_o=1 exactly 50 cycles after the second match; match_idx=2.
- len=0, start=0xA5, done=0xFF5A; drive 0xA5 then 0xFF5A 37 cycles later -> pass=1, latency=37, match_idx=0.
- Assert wb_rst_i for 1 cycle mid-RUN -> all outputs 0 the next cycle and FSM = IDLE. Re-arm and replay scenario 1 -> identical results (entries retained).
- Mid-RUN arm pulse, then the full sequence replayed -> pass, with latency measured from the second start only. cfg_we during busy does not alter the entries.
